// File: rtl/inst_fetch.sv
// inst_fetch: owns the architectural PC and fetches instruction words from a
// variable-latency memory over a req/ack handshake. Fetched words are handed
// to the datapath with a valid/ready handshake. Taken-branch redirects
// discard any fetch still in flight. All outputs are driven from flops.
module inst_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  fetch_en,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic                  inst_valid,
  output logic [INST_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  input  logic                  inst_ready,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  misaligned_err
);

  localparam logic [INST_WIDTH-1:0] NOP_WORD = INST_WIDTH'(32'h0000_0013);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(3'd4);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DROP  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  // Instruction addresses must sit on a 4-byte boundary.
  function automatic logic is_aligned(input logic [ADDR_WIDTH-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_pending_pc;
  logic                  r_imem_req;
  logic [ADDR_WIDTH-1:0] r_imem_addr;
  logic                  r_inst_valid;
  logic [INST_WIDTH-1:0] r_instruction;
  logic [ADDR_WIDTH-1:0] r_inst_pc;
  logic                  r_misaligned_err;

  logic [ADDR_WIDTH-1:0] w_pc_nxt;
  logic [ADDR_WIDTH-1:0] w_pending_pc_nxt;
  logic                  w_imem_req_nxt;
  logic [ADDR_WIDTH-1:0] w_imem_addr_nxt;
  logic                  w_inst_valid_nxt;
  logic [INST_WIDTH-1:0] w_instruction_nxt;
  logic [ADDR_WIDTH-1:0] w_inst_pc_nxt;
  logic                  w_misaligned_err_nxt;

  logic                  w_redir_ok;
  logic                  w_redir_bad;
  logic                  w_launch;

  // A misaligned redirect never moves the PC; it only raises the sticky error.
  assign w_redir_ok  = redirect & is_aligned(redirect_pc);
  assign w_redir_bad = redirect & ~is_aligned(redirect_pc);
  // A redirect arriving in IDLE updates the PC first so the stale PC is never fetched.
  assign w_launch    = fetch_en & ~r_misaligned_err & ~redirect;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state selection.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_launch) begin
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          w_state_nxt = redirect ? S_IDLE : S_HOLD;
        end else if (redirect) begin
          w_state_nxt = S_DROP;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_DROP: begin
        if (imem_ack) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DROP;
        end
      end
      S_HOLD: begin
        if (redirect || inst_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the PC and of every registered output.
  always_comb begin
    w_pc_nxt             = r_pc;
    w_pending_pc_nxt     = r_pending_pc;
    w_imem_req_nxt       = r_imem_req;
    w_imem_addr_nxt      = r_imem_addr;
    w_inst_valid_nxt     = r_inst_valid;
    w_instruction_nxt    = r_instruction;
    w_inst_pc_nxt        = r_inst_pc;
    w_misaligned_err_nxt = r_misaligned_err | w_redir_bad;
    case (r_state)
      S_IDLE: begin
        if (w_redir_ok) begin
          w_pc_nxt = redirect_pc;
        end else if (w_launch) begin
          w_imem_addr_nxt = r_pc;
          w_imem_req_nxt  = 1'b1;
        end else begin
          w_imem_req_nxt  = 1'b0;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          w_imem_req_nxt = 1'b0;
          if (!redirect) begin
            w_instruction_nxt = imem_rdata;
            w_inst_pc_nxt     = r_pc;
            w_inst_valid_nxt  = 1'b1;
            w_pc_nxt          = r_pc + PC_STEP;
          end else if (w_redir_ok) begin
            w_pc_nxt = redirect_pc;
          end else begin
            w_pc_nxt = r_pc;
          end
        end else if (redirect) begin
          // The request cannot be retracted; remember where to go once it lands.
          w_pending_pc_nxt = w_redir_ok ? redirect_pc : r_pc;
        end else begin
          w_pending_pc_nxt = r_pending_pc;
        end
      end
      S_DROP: begin
        if (w_redir_ok) begin
          w_pending_pc_nxt = redirect_pc;
        end else begin
          w_pending_pc_nxt = r_pending_pc;
        end
        if (imem_ack) begin
          w_imem_req_nxt = 1'b0;
          w_pc_nxt       = w_redir_ok ? redirect_pc : r_pending_pc;
        end else begin
          w_imem_req_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect || inst_ready) begin
          w_inst_valid_nxt = 1'b0;
          if (w_redir_ok) begin
            w_pc_nxt = redirect_pc;
          end else begin
            w_pc_nxt = r_pc;
          end
        end else begin
          w_inst_valid_nxt = 1'b1;
        end
      end
      default: begin
        w_imem_req_nxt   = 1'b0;
        w_inst_valid_nxt = 1'b0;
      end
    endcase
  end

  // PC and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc             <= RESET_PC;
      r_pending_pc     <= RESET_PC;
      r_imem_req       <= 1'b0;
      r_imem_addr      <= RESET_PC;
      r_inst_valid     <= 1'b0;
      r_instruction    <= NOP_WORD;
      r_inst_pc        <= RESET_PC;
      r_misaligned_err <= 1'b0;
    end else begin
      r_pc             <= w_pc_nxt;
      r_pending_pc     <= w_pending_pc_nxt;
      r_imem_req       <= w_imem_req_nxt;
      r_imem_addr      <= w_imem_addr_nxt;
      r_inst_valid     <= w_inst_valid_nxt;
      r_instruction    <= w_instruction_nxt;
      r_inst_pc        <= w_inst_pc_nxt;
      r_misaligned_err <= w_misaligned_err_nxt;
    end
  end

  assign imem_req       = r_imem_req;
  assign imem_addr      = r_imem_addr;
  assign inst_valid     = r_inst_valid;
  assign instruction    = r_instruction;
  assign inst_pc        = r_inst_pc;
  assign misaligned_err = r_misaligned_err;

endmodule
